// File: rtl/bnn_layer_sequencer.sv
// bnn_layer_sequencer: buffers one binarized frame and runs a shared XNOR-popcount engine over all MLP layers
// clk/xrst        : rising-edge clock, asynchronous active-high reset
// pix/pix_valid/pix_ready : pixel stream in, transfer = pix_valid & pix_ready, accepted only in LOAD
// w_rd/w_addr/w_bit       : weight ROM port, w_bit returns one cycle after w_rd
// t_addr/t_data           : threshold ROM port, t_addr held for a whole neuron
// busy                    : high while the layers are being evaluated
// pred/pred_valid         : prediction (MSB = output neuron 0) with a one-cycle update strobe
module bnn_layer_sequencer #(
    parameter int WIDTH_IN  = 784,
    parameter int WIDTH_MID = 16,
    parameter int WIDTH_OUT = 10,
    parameter int DEPTH     = 1,
    parameter int COUNT_BIT = 16,
    parameter int PIX_TH    = 64,
    parameter int W_ADDR_W  = 14,
    parameter int T_ADDR_W  = 6
) (
    input  logic                 clk,
    input  logic                 xrst,
    input  logic [7:0]           pix,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    output logic                 w_rd,
    output logic [W_ADDR_W-1:0]  w_addr,
    input  logic                 w_bit,
    output logic [T_ADDR_W-1:0]  t_addr,
    input  logic [COUNT_BIT-1:0] t_data,
    output logic                 busy,
    output logic [WIDTH_OUT-1:0] pred,
    output logic                 pred_valid
);
    localparam int I_W = $clog2(WIDTH_IN);
    localparam int C_W = $clog2(WIDTH_IN + 2);
    localparam int M_W = $clog2(WIDTH_MID);
    localparam int L_W = $clog2(DEPTH + 2);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    state_t state, state_nxt;

    logic [I_W-1:0]       pix_cnt;
    logic [C_W-1:0]       cnt, k;
    logic [M_W-1:0]       n;
    logic [L_W-1:0]       layer;
    logic [COUNT_BIT-1:0] acc;
    logic [WIDTH_IN-1:0]  img;
    logic [WIDTH_MID-1:0] act_buf [2];
    logic [WIDTH_OUT-2:0] shadow;
    logic [31:0]          fan_in;
    logic xfer, last_pix, commit, last_n, last_layer, done_now, act, x;

    always_comb begin
        xfer       = pix_valid & pix_ready;
        last_pix   = pix_cnt == I_W'(WIDTH_IN - 1);
        busy       = state == RUN;
        last_layer = layer == L_W'(DEPTH + 1);
        fan_in     = layer == '0 ? 32'(WIDTH_IN) : 32'(WIDTH_MID);
        commit     = busy && 32'(cnt) == fan_in + 32'd1;
        last_n     = n == M_W'((last_layer ? WIDTH_OUT : WIDTH_MID) - 1);
        done_now   = commit && last_layer && last_n;
        // cnt runs one ahead of the input index because w_bit arrives a cycle after its address
        k          = cnt - C_W'(1);
        // layer L reads the ping-pong half written by layer L-1
        x          = layer == '0 ? img[k[I_W-1:0]] : act_buf[~layer[0]][k[M_W-1:0]];
        act        = acc > t_data;
        w_rd       = busy && 32'(cnt) < fan_in;
        w_addr     = w_rd ? W_ADDR_W'((layer == '0 ? 32'd0 : 32'(WIDTH_MID * WIDTH_IN)
                         + (32'(layer) - 32'd1) * 32'(WIDTH_MID * WIDTH_MID))
                         + 32'(n) * fan_in + 32'(cnt)) : '0;
        t_addr     = busy ? T_ADDR_W'(32'(WIDTH_MID) * 32'(layer) + 32'(n)) : '0;
        state_nxt  = state == IDLE ? LOAD :
                     state == LOAD ? (xfer && last_pix ? RUN : LOAD) :
                     state == RUN  ? (done_now ? DONE : RUN) : LOAD;
    end

    always_ff @(posedge clk or posedge xrst) begin
        if (xrst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or posedge xrst) begin
        if (xrst) begin
            pix_cnt    <= '0;
            cnt        <= '0;
            n          <= '0;
            layer      <= '0;
            acc        <= '0;
            pix_ready  <= 1'b0;
            pred       <= '0;
            pred_valid <= 1'b0;
        end else begin
            pix_ready  <= state_nxt == LOAD;
            pred_valid <= done_now;
            if (xfer) pix_cnt <= last_pix ? '0 : pix_cnt + 1'b1;
            if (commit) begin
                cnt <= '0;
                acc <= '0;
                n   <= last_n ? '0 : n + 1'b1;
                if (last_n) layer <= last_layer ? '0 : layer + 1'b1;
            end else if (busy) begin
                cnt <= cnt + 1'b1;
                if (cnt != '0) acc <= acc + COUNT_BIT'(w_bit == x);
            end
            if (done_now) pred <= {shadow, act};
        end
    end

    // frame and activation storage carries no reset; output neurons shift in so neuron 0 ends at the MSB
    always_ff @(posedge clk) begin
        if (xfer) img[pix_cnt] <= pix > 8'(PIX_TH);
        if (commit && last_layer) shadow <= {shadow[WIDTH_OUT-3:0], act};
        else if (commit) act_buf[layer[0]][n] <= act;
    end
endmodule
